umi_regif_arbiter: RTL
======================

// Module: umi_regif_arbiter
// PURPOSE
// - Shares one register-interface target (reg_* bus) between N UMI device request ports.
// - Round-robin arbitration; one granted transaction at a time.
// - Holds each response in a single register until the owning port accepts it.
// - Sits between N UMI endpoints (e.g. host link, debug port) and one block's register file.
// PARAMETERS
// N       2    number of UMI requester ports (>=2)
// AW      64   address width
// CW      32   UMI command width
// DW      256  UMI data width (integer multiple of RW)
// RW      64   register width
// PORTS
// clk                 in   1      clock
// nreset              in   1      asynchronous active-low reset
// udev_req_valid      in   N      per-port request valid
// udev_req_cmd        in   N*CW   per-port command (port i at [i*CW+:CW])
// udev_req_dstaddr    in   N*AW   per-port destination address
// udev_req_srcaddr    in   N*AW   per-port source (return) address
// udev_req_data       in   N*DW   per-port write data
// udev_req_ready      out  N      per-port ready (at most one bit high)
// udev_resp_valid     out  N      per-port response valid (at most one bit high)
// udev_resp_cmd       out  CW     shared response command (qualified by udev_resp_valid)
// udev_resp_dstaddr   out  AW     shared response dstaddr
// udev_resp_srcaddr   out  AW     shared response srcaddr
// udev_resp_data      out  DW     shared response data
// udev_resp_ready     in   N      per-port response ready
// reg_addr            out  AW     register address
// reg_write           out  1      register write strobe (1 cycle)
// reg_read            out  1      register read strobe (1 cycle)
// reg_opcode          out  5      request opcode
// reg_size            out  3      request size
// reg_len             out  8      request len
// reg_wrdata          out  RW     write data = granted req data[RW-1:0]
// reg_rddata          in   RW     read data, valid combinationally in the reg_read cycle
// BEHAVIOUR
// - States: IDLE, RESP. Reset -> IDLE; priority pointer = port 0.
// - Reset values: udev_req_ready=0, udev_resp_valid=0, all resp_* registers 0.
// - IDLE arbitration:
//   - grant = first valid port at or after the pointer, wrapping N-1 -> 0.
//   - udev_req_ready = onehot(grant) only in IDLE; no grant => ready all 0.
//   - udev_req_ready is combinational from state/pointer/valid.
// - Accept cycle (valid&ready, port g):
//   - reg_* driven combinationally from port g fields.
//   - Pointer <= g+1 mod N.
// - Command handling on accept:
//   - read: reg_read=1; capture resp; -> RESP.
//   - write (acked): reg_write=1; capture resp; -> RESP.
//   - posted write: reg_write=1; no response; stay IDLE.
//     - Back-to-back posted writes sustain 1/cycle.
//   - any other opcode (atomic, rdma, user, ...):
//     - no reg strobe; capture resp with err=2'b10; -> RESP.
// - Response capture (registered at accept edge):
//   - resp_cmd = req cmd with opcode replaced (RESP_READ for read, else RESP_WRITE).
//   - resp_dstaddr = req srcaddr.
//   - resp_srcaddr = req dstaddr.
//   - resp_data = reg_rddata replicated DW/RW times (reads); 0 otherwise.
// - RESP:
//   - udev_resp_valid[g]=1 and all resp_* held stable until udev_resp_ready[g].
//   - On that handshake -> IDLE; new grant possible in the next cycle.
//   - Acked transaction rate max 1 per 2 cycles.
//   - No requests are accepted while in RESP; other ports stall (no starvation: pointer rotates).
//   - udev_resp_ready of non-owning ports is ignored.
// - Reset mid-transaction: pending response discarded; returns to IDLE, pointer 0.
// - Requests whose size/len exceed RW are forwarded unchanged (target's responsibility).
// TESTING
// - Reset: hold all valids high during nreset=0 -> ready=0, resp_valid=0; first grant after release = port 0.
// - Contention: ports 0,1 both issue reads continuously with resp_ready=1 -> grants alternate 0,1,0,1; one read per 2 cycles.
// - Read data path: port1 read dstaddr=0x10, srcaddr=0xABC0, reg_rddata=0x1234 -> resp_valid[1], cmd opcode RESP_READ, dstaddr=0xABC0, data = 4x 0x1234 (DW=256).
// - Backpressure: port0 write, udev_resp_ready[0]=0 for 5 cycles -> response stable 5 cycles; port1 request not granted until cycle after handshake.
// - Posted writes: port0 issues 4 back-to-back posted writes -> 4 reg_write pulses on 4 consecutive cycles, no responses.
// - Unsupported/reset: port0 atomic -> no reg strobe, resp err=2'b10; assert nreset while in RESP -> resp_valid drops immediately, IDLE after release.

Source files
------------

// File: rtl/umi_regif_arbiter.sv
// umi_regif_arbiter
// Shares one register-interface target between N UMI device request ports.
// Requests are granted round-robin, one transaction at a time. Reads, acked
// writes and unsupported opcodes produce a response held in a single register
// set until the owning port accepts it. Posted writes complete in the accept
// cycle and never produce a response.
//
// Ports
//   clk, nreset          clock, asynchronous active-low reset
//   udev_req_*           N request ports, packed per port (port i at [i*W+:W])
//   udev_req_ready       one-hot grant, combinational, only while idle
//   udev_resp_*          shared registered response, owner flagged in udev_resp_valid
//   udev_resp_ready      per-port response accept (only the owner's bit is used)
//   reg_*                register target bus, driven from the granted request
//   reg_rddata           read data, expected combinationally in the reg_read cycle
//
// UMI command fields used: opcode [4:0], size [7:5], len [15:8], and the
// response error field [26:25]. UMI commands are 32 bits wide, so CW must be
// at least 27.
module umi_regif_arbiter #(
  parameter int N  = 2,
  parameter int AW = 64,
  parameter int CW = 32,
  parameter int DW = 256,
  parameter int RW = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    udev_req_valid,
  input  logic [N*CW-1:0] udev_req_cmd,
  input  logic [N*AW-1:0] udev_req_dstaddr,
  input  logic [N*AW-1:0] udev_req_srcaddr,
  input  logic [N*DW-1:0] udev_req_data,
  output logic [N-1:0]    udev_req_ready,
  output logic [N-1:0]    udev_resp_valid,
  output logic [CW-1:0]   udev_resp_cmd,
  output logic [AW-1:0]   udev_resp_dstaddr,
  output logic [AW-1:0]   udev_resp_srcaddr,
  output logic [DW-1:0]   udev_resp_data,
  input  logic [N-1:0]    udev_resp_ready,
  output logic [AW-1:0]   reg_addr,
  output logic            reg_write,
  output logic            reg_read,
  output logic [4:0]      reg_opcode,
  output logic [2:0]      reg_size,
  output logic [7:0]      reg_len,
  output logic [RW-1:0]   reg_wrdata,
  input  logic [RW-1:0]   reg_rddata
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [4:0] REQ_READ     = 5'h01;
  localparam logic [4:0] REQ_WRITE    = 5'h03;
  localparam logic [4:0] REQ_WRPOSTED = 5'h05;
  localparam logic [4:0] RESP_READ    = 5'h02;
  localparam logic [4:0] RESP_WRITE   = 5'h04;

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] owner_reg;

  // Per-port views of the packed request buses
  logic [CW-1:0] cmd_arr   [N];
  logic [AW-1:0] dst_arr   [N];
  logic [AW-1:0] src_arr   [N];
  logic [RW-1:0] wdata_arr [N];
  logic [N-1:0]  unused_data_hi;

  for (genvar gi = 0; gi < N; gi++) begin : g_port
    assign cmd_arr[gi]   = udev_req_cmd[gi*CW +: CW];
    assign dst_arr[gi]   = udev_req_dstaddr[gi*AW +: AW];
    assign src_arr[gi]   = udev_req_srcaddr[gi*AW +: AW];
    assign wdata_arr[gi] = udev_req_data[gi*DW +: RW];
    // Only the low register word of the request data reaches the target.
    if (DW > RW) begin : g_hi
      assign unused_data_hi[gi] = ^udev_req_data[gi*DW+RW +: DW-RW];
    end else begin : g_nohi
      assign unused_data_hi[gi] = 1'b0;
    end
  end

  // Round-robin search: scan from the farthest candidate back to the pointer
  // so the last hit is the first valid port at or after the pointer.
  logic [PW-1:0] grant;
  logic          grant_any;
  logic [PW:0]   cand;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (udev_req_valid[cand[PW-1:0]]) begin
        grant     = cand[PW-1:0];
        grant_any = 1'b1;
      end
    end
  end

  // Gating with nreset keeps ready low while reset is held even though the
  // state register already reads IDLE.
  logic accept;
  assign accept = nreset && (state_reg == IDLE) && grant_any;

  logic [CW-1:0] sel_cmd;
  logic [4:0]    sel_op;
  logic          is_read, is_write, is_posted;

  assign sel_cmd   = cmd_arr[grant];
  assign sel_op    = sel_cmd[4:0];
  assign is_read   = (sel_op == REQ_READ);
  assign is_write  = (sel_op == REQ_WRITE);
  assign is_posted = (sel_op == REQ_WRPOSTED);

  always_comb begin
    udev_req_ready = '0;
    if (accept) udev_req_ready[grant] = 1'b1;
  end

  always_comb begin
    udev_resp_valid = '0;
    if (state_reg == RESP) udev_resp_valid[owner_reg] = 1'b1;
  end

  // Register target bus follows the granted port; strobes only on accept.
  assign reg_addr   = dst_arr[grant];
  assign reg_opcode = sel_op;
  assign reg_size   = sel_cmd[7:5];
  assign reg_len    = sel_cmd[15:8];
  assign reg_wrdata = wdata_arr[grant];
  assign reg_read   = accept && is_read;
  assign reg_write  = accept && (is_write || is_posted);

  // Next-state and response capture
  logic          capture;
  logic [CW-1:0] resp_cmd_next;
  logic [DW-1:0] resp_data_next;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && !is_posted) begin
          state_next = RESP;
          capture    = 1'b1;
        end
      end
      RESP: begin
        if (udev_resp_ready[owner_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_cmd_next      = sel_cmd;
    resp_cmd_next[4:0] = is_read ? RESP_READ : RESP_WRITE;
    // Anything that is not a plain read or acked write is answered with an error.
    if (!(is_read || is_write)) resp_cmd_next[26:25] = 2'b10;
    resp_data_next = is_read ? {(DW/RW){reg_rddata}} : '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ptr_reg <= (grant == PW'(N - 1)) ? '0 : grant + PW'(1);
      end
      if (capture) owner_reg <= grant;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      udev_resp_cmd     <= '0;
      udev_resp_dstaddr <= '0;
      udev_resp_srcaddr <= '0;
      udev_resp_data    <= '0;
    end else if (capture) begin
      udev_resp_cmd     <= resp_cmd_next;
      udev_resp_dstaddr <= src_arr[grant];
      udev_resp_srcaddr <= dst_arr[grant];
      udev_resp_data    <= resp_data_next;
    end
  end

endmodule
